// File: rtl/timer_pkg.sv
// Shared types and constants for the M:SS BCD countdown timer.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int unsigned DONE_TICKS_DEF = 10;

   localparam logic [3:0] DIG2_MAX = 4'd1;
   localparam logic [3:0] DIG1_MAX = 4'd5;
   localparam logic [3:0] DIG0_MAX = 4'd9;

   // BCD presets {d2,d1,d0}, indexed by mode: 0:30, 1:00, 1:30, 0:10
   localparam logic [11:0] PRESETS [4] = '{12'h030, 12'h100, 12'h130, 12'h010};

   function automatic logic [11:0] preset_bcd(input logic [1:0] m);
      return PRESETS[m];
   endfunction

endpackage

// File: rtl/done_alarm.sv
// Alarm phase timer: blink toggle and DONE-duration counter, cleared on DONE entry.
module done_alarm #(
   parameter int unsigned DONE_TICKS = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic tick,
   output logic blink,
   output logic expire
);

   logic [3:0] cnt_q, cnt_d;
   logic       blink_q, blink_d;

   // expire fires on the tick that would bring the count to DONE_TICKS
   assign expire = tick & ~clr & (cnt_q == 4'(DONE_TICKS - 1));
   assign blink  = blink_q;

   always_comb begin
      cnt_d   = cnt_q;
      blink_d = blink_q;
      if (clr) begin
         cnt_d   = 4'd0;
         blink_d = 1'b0;
      end else if (tick) begin
         cnt_d   = cnt_q + 4'd1;
         blink_d = ~blink_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 4'd0;
         blink_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         blink_q <= blink_d;
      end
   end

endmodule

// File: rtl/countdown_ctrl.sv
// Start/pause/done sequencer and preset selector for the BCD countdown chain.
module countdown_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned DONE_TICKS = DONE_TICKS_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_pulse,
   input  logic        mode_pulse,
   input  logic        clear_pulse,
   input  logic        tick,
   input  logic        zero,
   output logic        load,
   output logic        dec_en,
   output logic [3:0]  preset_d2,
   output logic [3:0]  preset_d1,
   output logic [3:0]  preset_d0,
   output logic [1:0]  mode,
   output logic        running,
   output logic        done,
   output logic [15:0] led,
   output logic [1:0]  state_dbg
);

   state_t     state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic       alarm_clr;
   logic       alarm_tick;
   logic       blink;
   logic       expire;

   assign alarm_clr  = (state_d == ST_DONE) && (state_q != ST_DONE);
   assign alarm_tick = tick && (state_q == ST_DONE);

   done_alarm #(.DONE_TICKS(DONE_TICKS)) u_alarm (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (alarm_clr),
      .tick   (alarm_tick),
      .blink  (blink),
      .expire (expire)
   );

   // Priority: clear > zero (RUN) > start > tick > mode
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_pulse)     state_d = ST_RUN;
            else if (mode_pulse) mode_d  = mode_q + 2'd1;
         end
         ST_RUN: begin
            if (zero)             state_d = ST_PAUSE == ST_PAUSE ? ST_DONE : ST_DONE;
            else if (start_pulse) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (start_pulse) state_d = ST_RUN;
         end
         ST_DONE: begin
            if (start_pulse || expire) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (clear_pulse) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mode_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
      end
   end

   // Mealy decrement: one clk wide, coincident with tick
   assign dec_en = (state_q == ST_RUN) & tick & ~zero & ~clear_pulse;

   assign load      = (state_q == ST_IDLE);
   assign running   = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign led       = (done && blink) ? 16'hFFFF : 16'h0000;
   assign mode      = mode_q;
   assign state_dbg = state_q;
   assign {preset_d2, preset_d1, preset_d0} = preset_bcd(mode_q);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl with a behavioural BCD counter chain in the loop.
module tb_countdown_ctrl;
   import timer_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start_pulse, mode_pulse, clear_pulse, tick;
   logic        zero;
   logic        load, dec_en, running, done;
   logic [3:0]  preset_d2, preset_d1, preset_d0;
   logic [1:0]  mode;
   logic [15:0] led;
   logic [1:0]  state_dbg;

   countdown_ctrl #(.DONE_TICKS(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_pulse (start_pulse),
      .mode_pulse  (mode_pulse),
      .clear_pulse (clear_pulse),
      .tick        (tick),
      .zero        (zero),
      .load        (load),
      .dec_en      (dec_en),
      .preset_d2   (preset_d2),
      .preset_d1   (preset_d1),
      .preset_d0   (preset_d0),
      .mode        (mode),
      .running     (running),
      .done        (done),
      .led         (led),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural counter chain
   logic [3:0] m2, m1, m0;
   logic [11:0] pre_tab [4];
   initial pre_tab = '{12'h030, 12'h100, 12'h130, 12'h010};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m2 <= 4'd0; m1 <= 4'd0; m0 <= 4'd0;
      end else if (load) begin
         {m2, m1, m0} <= {preset_d2, preset_d1, preset_d0};
      end else if (dec_en) begin
         if (m0 != 4'd0) m0 <= m0 - 4'd1;
         else begin
            m0 <= DIG0_MAX;
            if (m1 != 4'd0) m1 <= m1 - 4'd1;
            else begin
               m1 <= DIG1_MAX;
               m2 <= (m2 == 4'd0) ? DIG2_MAX : m2 - 4'd1;
            end
         end
      end
   end
   assign zero = (m2 == 4'd0) && (m1 == 4'd0) && (m0 == 4'd0);

   // scoreboard
   int total = 0;
   int bad   = 0;
   int dec_cnt = 0;
   logic [39:0] exp_q[$];

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (dec_en) dec_cnt++;
         check("dec_at_zero", {39'd0, dec_en & zero}, 40'd0);
      end
   end

   task automatic expect_st(input state_t st, input logic [1:0] md, input logic [15:0] ledv);
      exp_q.push_back({5'd0, 2'(st), md, st == ST_IDLE, st == ST_RUN, st == ST_DONE,
                       ledv, pre_tab[md]});
   endtask

   task automatic check_out(input string tag);
      logic [39:0] got;
      got = {5'd0, state_dbg, mode, load, running, done, led, preset_d2, preset_d1, preset_d0};
      if (exp_q.size() == 0) check({tag, "_noexp"}, got, 40'hXX);
      else check(tag, got, exp_q.pop_front());
   endtask

   // drivers
   task automatic step(input logic sp, input logic mp, input logic cp, input logic tk);
      start_pulse = sp; mode_pulse = mp; clear_pulse = cp; tick = tk;
      @(posedge clk);
      #1;
      start_pulse = 0; mode_pulse = 0; clear_pulse = 0; tick = 0;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst_n = 0; start_pulse = 0; mode_pulse = 0; clear_pulse = 0; tick = 0;
      repeat (3) @(posedge clk);
      #1;
      expect_st(ST_IDLE, 2'd0, 16'h0000); check_out("reset");
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;

      // mode cycling in IDLE
      for (int i = 1; i <= 4; i++) begin
         step(0, 1, 0, 0);
         expect_st(ST_IDLE, 2'(i), 16'h0000); check_out($sformatf("mode_%0d", i));
      end
      repeat (3) step(0, 1, 0, 0);
      expect_st(ST_IDLE, 2'd3, 16'h0000); check_out("mode_back3");

      // full run from 0:10
      step(1, 0, 0, 0);
      expect_st(ST_RUN, 2'd3, 16'h0000); check_out("start_run");
      d0 = dec_cnt;
      run_ticks(10);
      check("dec_count10", 40'(dec_cnt - d0), 40'd10);
      check("zero_after10", {39'd0, zero}, 40'd1);
      expect_st(ST_RUN, 2'd3, 16'h0000); check_out("run_1clk_after");
      step(0, 0, 0, 1);
      check("no_dec_at_zero", 40'(dec_cnt - d0), 40'd10);
      expect_st(ST_DONE, 2'd3, 16'h0000); check_out("done_2clk");

      // DONE blink and auto-return
      for (int i = 1; i <= 4; i++) begin
         step(0, 0, 0, 1);
         expect_st(ST_DONE, 2'd3, (i % 2) ? 16'hFFFF : 16'h0000);
         check_out($sformatf("blink_%0d", i));
      end
      step(0, 1, 0, 0);
      expect_st(ST_DONE, 2'd3, 16'h0000); check_out("done_mode_ignored");
      run_ticks(5);
      expect_st(ST_DONE, 2'd3, 16'hFFFF); check_out("done_tick9");
      step(0, 0, 0, 1);
      expect_st(ST_IDLE, 2'd3, 16'h0000); check_out("done_expire");

      // pause holds the count
      step(1, 0, 0, 0);
      step(0, 0, 0, 1);
      check("run_one_tick", {28'd0, m2, m1, m0}, 40'h009);
      step(1, 0, 0, 0);
      expect_st(ST_PAUSE, 2'd3, 16'h0000); check_out("pause");
      d0 = dec_cnt;
      run_ticks(3);
      check("pause_no_dec", 40'(dec_cnt - d0), 40'd0);
      check("pause_hold", {28'd0, m2, m1, m0}, 40'h009);
      step(1, 0, 0, 0);
      expect_st(ST_RUN, 2'd3, 16'h0000); check_out("resume");

      // same-cycle stimulus
      step(0, 1, 0, 0);
      expect_st(ST_RUN, 2'd3, 16'h0000); check_out("run_mode_ignored");
      d0 = dec_cnt;
      step(1, 0, 0, 1);
      check("tick_with_start", 40'(dec_cnt - d0), 40'd1);
      expect_st(ST_PAUSE, 2'd3, 16'h0000); check_out("start_tick_pause");
      step(1, 0, 1, 0);
      expect_st(ST_IDLE, 2'd3, 16'h0000); check_out("clear_over_start");

      // start_pulse leaves DONE
      step(1, 0, 0, 0);
      run_ticks(10);
      step(0, 0, 0, 0);
      expect_st(ST_DONE, 2'd3, 16'h0000); check_out("done_again");
      step(1, 0, 0, 0);
      expect_st(ST_IDLE, 2'd3, 16'h0000); check_out("done_start_idle");

      // zero beats start in RUN
      step(1, 0, 0, 0);
      run_ticks(10);
      step(1, 0, 0, 0);
      expect_st(ST_DONE, 2'd3, 16'h0000); check_out("zero_over_start");
      step(0, 0, 1, 0);
      expect_st(ST_IDLE, 2'd3, 16'h0000); check_out("clear_done");

      // async reset mid-RUN, between edges
      step(1, 0, 0, 0);
      step(0, 0, 0, 1);
      tick = 1;
      #1;
      check("pre_rst_dec", {39'd0, dec_en}, 40'd1);
      rst_n = 0;
      #1;
      expect_st(ST_IDLE, 2'd0, 16'h0000); check_out("async_rst");
      check("async_rst_dec", {39'd0, dec_en}, 40'd0);
      tick = 0;
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      expect_st(ST_IDLE, 2'd0, 16'h0000); check_out("post_rst");

      check("sb_empty", 40'(exp_q.size()), 40'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
